// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-write target.
// Read support is compiled in when I2C_TARGET_READ_EN is defined.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_MACK,
    ST_IGNORE
  } i2c_state_e;

  localparam int         RW_BIT       = 0;
  localparam logic       RW_WRITE     = 1'b0;
  localparam logic       RW_READ      = 1'b1;
  localparam logic       ACK_LVL      = 1'b0;
  localparam logic       NACK_LVL     = 1'b1;
  localparam logic       BUS_IDLE     = 1'b1;
  localparam logic [6:0] DEF_DEV_ADDR = 7'h40;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizer with a history stage; produces SCL edge and START/STOP pulses.
module i2c_bus_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, scl_hist_d;
  logic                   sda_hist_q, sda_hist_d;
  logic                   scl_s, sda_s;

  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], i_scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], i_sda};
    scl_hist_d = scl_sync_q[SYNC_STAGES-1];
    sda_hist_d = sda_sync_q[SYNC_STAGES-1];
  end

  // Reset to the released-bus level so no spurious edge appears on exit.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_sync_q <= {SYNC_STAGES{BUS_IDLE}};
      sda_sync_q <= {SYNC_STAGES{BUS_IDLE}};
      scl_hist_q <= BUS_IDLE;
      sda_hist_q <= BUS_IDLE;
    end else begin
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
    end
  end

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign o_sda      = sda_s;
  assign o_scl_rise = scl_s & ~scl_hist_q;
  assign o_scl_fall = ~scl_s & scl_hist_q;
  assign o_start    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
  assign o_stop     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target front end issuing register-write strobes with an auto-incrementing pointer.
// Define I2C_TARGET_READ_EN to add register reads (o_rd_addr / i_rd_data).
//
// state         | meaning
// ST_IDLE       | waiting for START
// ST_ADDR       | shifting in device address + R/W
// ST_ADDR_ACK   | holding SDA low for the address ACK
// ST_REG        | shifting in the register pointer
// ST_REG_ACK    | ACK of pointer byte
// ST_WDATA      | shifting in a data byte
// ST_WDATA_ACK  | ACK of data byte, pointer increments on exit
// ST_RDATA      | driving a read byte
// ST_RDATA_MACK | sampling controller ACK/NACK
// ST_IGNORE     | not addressed, waiting for START/STOP
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEF_DEV_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_wr_en,
  output logic [7:0] o_wr_addr,
  output logic [7:0] o_wr_data,
`ifdef I2C_TARGET_READ_EN
  output logic [7:0] o_rd_addr,
  input  logic [7:0] i_rd_data,
`endif
  output logic       o_busy
);

`ifdef I2C_TARGET_READ_EN
  localparam logic READ_OK = 1'b1;
`else
  localparam logic READ_OK = 1'b0;
`endif

  logic sda_s, scl_rise, scl_fall, bus_start, bus_stop;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_scl      (i_scl),
    .i_sda      (i_sda),
    .o_sda      (sda_s),
    .o_scl_rise (scl_rise),
    .o_scl_fall (scl_fall),
    .o_start    (bus_start),
    .o_stop     (bus_stop)
  );

  i2c_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       oe_q, oe_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       bit_in, byte_done;

  assign bit_in    = scl_rise && (cnt_q < 4'd8);
  assign byte_done = scl_fall && (cnt_q == 4'd8);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    oe_d      = oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (bus_start) begin
      state_d = ST_ADDR;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else if (bus_stop) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (bit_in) begin
            sr_d  = {sr_q[6:0], sda_s};
            cnt_d = cnt_q + 4'd1;
          end else if (byte_done) begin
            cnt_d = 4'd0;
            if (state_q == ST_ADDR) begin
              rw_d = sr_q[RW_BIT];
              if (sr_q[7:1] == DEV_ADDR && (sr_q[RW_BIT] == RW_WRITE || READ_OK)) begin
                state_d = ST_ADDR_ACK;
                oe_d    = 1'b1;
              end else begin
                state_d = ST_IGNORE;
              end
            end else if (state_q == ST_REG) begin
              ptr_d   = sr_q;
              state_d = ST_REG_ACK;
              oe_d    = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = sr_q;
              state_d   = ST_WDATA_ACK;
              oe_d      = 1'b1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            oe_d = 1'b0;
            if (rw_q == RW_WRITE) state_d = ST_REG;
`ifdef I2C_TARGET_READ_EN
            else begin
              sr_d    = i_rd_data;
              oe_d    = ~i_rd_data[7];
              state_d = ST_RDATA;
            end
`endif
          end
        end
        ST_REG_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            state_d = ST_WDATA;
          end
        end
        ST_WDATA_ACK: begin
          if (scl_fall) begin
            oe_d    = 1'b0;
            ptr_d   = ptr_q + 8'd1;
            state_d = ST_WDATA;
          end
        end
`ifdef I2C_TARGET_READ_EN
        ST_RDATA: begin
          if (bit_in) begin
            cnt_d = cnt_q + 4'd1;
          end else if (byte_done) begin
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            state_d = ST_RDATA_MACK;
          end else if (scl_fall && cnt_q != 4'd0) begin
            sr_d = {sr_q[6:0], 1'b1};
            oe_d = ~sr_q[6];
          end
        end
        // Pointer moves on the ACK rise so i_rd_data settles before the load on the fall.
        ST_RDATA_MACK: begin
          if (scl_rise) begin
            if (sda_s == NACK_LVL) state_d = ST_IGNORE;
            else                   ptr_d   = ptr_q + 8'd1;
          end else if (scl_fall) begin
            sr_d    = i_rd_data;
            oe_d    = ~i_rd_data[7];
            cnt_d   = 4'd0;
            state_d = ST_RDATA;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      sr_q      <= 8'h00;
      ptr_q     <= 8'h00;
      rw_q      <= RW_WRITE;
      oe_q      <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      oe_q      <= oe_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_sda_oe  = oe_q;
  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;
  assign o_busy    = state_q inside {ST_ADDR_ACK, ST_REG, ST_REG_ACK, ST_WDATA,
                                     ST_WDATA_ACK, ST_RDATA, ST_RDATA_MACK};
`ifdef I2C_TARGET_READ_EN
  assign o_rd_addr = ptr_q;
`endif

endmodule
